fetch_controller: RTL

- Instruction-fetch sequencer for the pipelined core.
- Owns the PC and drives the address of the combinational InstructionMem, which returns the word in the same cycle.
- Registers the fetched instruction and its PC into the IF/ID stage with a valid/ready handshake.
- Handles branch redirects (flush), halt-word detection, and out-of-range fetch faults.

---
 rtl/fetch_controller.sv | 111 +++++++++++
 1 files changed

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives InstructionMem and fills the IF/ID register
// through a valid/ready handshake, with branch flush, halt-word stop and fetch-fault detection.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 64,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] PcLimit = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {StIdle, StRun, StHalt, StFault} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        redirect_bad;
  logic        accept;

  assign imem_addr    = pc_q;
  assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= PcLimit);
  // A redirect discards the held instruction, so it is never counted as accepted.
  assign accept       = out_valid && out_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= 32'h0;
      out_pc      <= 32'h0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      if (accept) begin
        fetch_count <= fetch_count + 32'd1;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (redirect_valid) begin
            out_valid <= 1'b0;
            if (redirect_bad) begin
              fault   <= 1'b1;
              state_q <= StFault;
            end else begin
              pc_q <= redirect_pc;
            end
          end else if (!out_valid || out_ready) begin
            if (pc_q >= PcLimit) begin
              fault     <= 1'b1;
              out_valid <= 1'b0;
              state_q   <= StFault;
            end else begin
              out_instr <= imem_instr;
              out_pc    <= pc_q;
              out_valid <= 1'b1;
              // The PC parks on the halt word so imem_addr stays there.
              if (imem_instr == HALT_WORD) begin
                state_q <= StHalt;
              end else begin
                pc_q <= pc_q + 32'd4;
              end
            end
          end
        end
        StHalt: begin
          if (!halted && redirect_valid) begin
            out_valid <= 1'b0;
            if (redirect_bad) begin
              fault   <= 1'b1;
              state_q <= StFault;
            end else begin
              pc_q    <= redirect_pc;
              state_q <= StRun;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            halted    <= 1'b1;
          end
        end
        StFault: begin
          out_valid <= 1'b0;
          fault     <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
